// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator.
//   phase_e    : per-axis phase encoding (ACTIVE, FRONT, SYNC, BACK, plus INIT
//                which is held only while in reset and during the cycle
//                immediately after reset is released)
//   next_phase : successor of a phase in the order ACTIVE -> FRONT -> SYNC ->
//                BACK -> ACTIVE. Zero-length phases are skipped, so a single
//                transition can pass over several empty phases.
package vga_timing_gen_pkg;

    typedef enum logic [2:0] {
        PH_ACTIVE = 3'd0,
        PH_FRONT  = 3'd1,
        PH_SYNC   = 3'd2,
        PH_BACK   = 3'd3,
        PH_INIT   = 3'd4
    } phase_e;

    // ACTIVE is never skipped because its length is clamped to at least 1.
    function automatic phase_e next_phase(input phase_e cur,
                                          input logic   fp_nz,
                                          input logic   sp_nz,
                                          input logic   bp_nz);
        phase_e nxt;
        case (cur)
            PH_ACTIVE: nxt = fp_nz ? PH_FRONT : (sp_nz ? PH_SYNC : (bp_nz ? PH_BACK : PH_ACTIVE));
            PH_FRONT:  nxt = sp_nz ? PH_SYNC : (bp_nz ? PH_BACK : PH_ACTIVE);
            PH_SYNC:   nxt = bp_nz ? PH_BACK : PH_ACTIVE;
            default:   nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: phase FSM plus in-phase counter. The H axis advances on
// every cycle; the V axis advances once per line.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (returns to INIT)
//   advance             step the axis by one unit this cycle
//   len_act/fp/sp/bp    phase lengths (ACTIVE length 0 is treated as 1)
//   phase_nxt           phase the axis enters after this clock edge
//   coord_nxt           coordinate after this edge (0 outside ACTIVE)
//   wrap                this is the final unit of the axis period
// The next-state values are exported so that the parent can register its
// outputs in the same cycle in which the axis state changes.
module vga_timing_gen_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic [W-1:0] len_act,
    input  logic [W-1:0] len_fp,
    input  logic [W-1:0] len_sp,
    input  logic [W-1:0] len_bp,
    output phase_e       phase_nxt,
    output logic [W-1:0] coord_nxt,
    output logic         wrap
);

    phase_e       phase;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cur_len;
    phase_e       nxt;

    always_comb begin
        case (phase)
            PH_ACTIVE: cur_len = (len_act == '0) ? W'(1) : len_act;
            PH_FRONT:  cur_len = len_fp;
            PH_SYNC:   cur_len = len_sp;
            default:   cur_len = len_bp;
        endcase

        nxt     = phase;
        cnt_nxt = cnt;
        wrap    = 1'b0;
        if (phase == PH_INIT) begin
            nxt     = PH_ACTIVE;
            cnt_nxt = '0;
        end else if (advance) begin
            if (cnt == cur_len - W'(1)) begin
                nxt     = next_phase(phase, len_fp != '0, len_sp != '0, len_bp != '0);
                cnt_nxt = '0;
                // Returning to ACTIVE ends the period, whichever phase was last.
                wrap    = (nxt == PH_ACTIVE);
            end else begin
                cnt_nxt = cnt + W'(1);
            end
        end

        phase_nxt = nxt;
        coord_nxt = (nxt == PH_ACTIVE) ? cnt_nxt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_INIT;
            cnt   <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator. Produces sync, display enable and pixel coordinates
// from timing parameters. Parameters are captured into shadow registers, and
// the shadow registers change only at a frame boundary, so a frame is never
// torn.
// Ports:
//   Clk, Rst                 pixel clock, asynchronous active-high reset
//   Load_config              1-cycle strobe: the live timing inputs are valid
//   H_/V_front_porch         front porch (pixels / lines)
//   H_/V_back_porch          back porch
//   H_/V_sync_pulse          sync width
//   H_/V_count_max           active pixels / lines
//   Hsync, Vsync             active-low sync
//   Display_en               high while both axes are in ACTIVE
//   Pixel_x, Pixel_y         active coordinate, 0 outside ACTIVE
//   Frame_start              pulse on the first cycle of pixel (0,0)
//   Frame_count (optional)   present only when VGA_TIMING_FRAME_CNT_EN is
//                            defined; counts frames and wraps 255 -> 0
// All outputs are registered from the axis next-state values.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int PORCH_WIDTH   = 8,
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Load_config,
    input  logic [PORCH_WIDTH-1:0]   H_front_porch,
    input  logic [PORCH_WIDTH-1:0]   H_back_porch,
    input  logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    input  logic [REZ_MAX_WIDTH-1:0] H_count_max,
    input  logic [PORCH_WIDTH-1:0]   V_front_porch,
    input  logic [PORCH_WIDTH-1:0]   V_back_porch,
    input  logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    input  logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic                     Hsync,
    output logic                     Vsync,
    output logic                     Display_en,
    output logic [REZ_MAX_WIDTH-1:0] Pixel_x,
    output logic [REZ_MAX_WIDTH-1:0] Pixel_y,
    output logic                     Frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]               Frame_count
`endif
);

    localparam int RW = REZ_MAX_WIDTH;

    logic [PORCH_WIDTH-1:0] h_fp_sh, h_bp_sh, v_fp_sh, v_bp_sh;
    logic [PULSE_WIDTH-1:0] h_sp_sh, v_sp_sh;
    logic [RW-1:0]          h_act_sh, v_act_sh;
    logic                   primed;
    logic                   pending;

    phase_e        h_phase_nxt, v_phase_nxt;
    logic [RW-1:0] h_coord_nxt, v_coord_nxt;
    logic          h_wrap, v_wrap;
    logic          frame_last;
    logic          reload;

    // V only reports a wrap while it is being advanced, so this marks the
    // final cycle of the frame.
    assign frame_last = h_wrap & v_wrap;
    // A strobe on the final cycle itself still takes effect for the next frame.
    assign reload     = !primed || (frame_last && (pending || Load_config));

    vga_timing_gen_axis_counter #(.W(RW)) u_h_axis (
        .clk       (Clk),
        .rst       (Rst),
        .advance   (1'b1),
        .len_act   (h_act_sh),
        .len_fp    (RW'(h_fp_sh)),
        .len_sp    (RW'(h_sp_sh)),
        .len_bp    (RW'(h_bp_sh)),
        .phase_nxt (h_phase_nxt),
        .coord_nxt (h_coord_nxt),
        .wrap      (h_wrap)
    );

    vga_timing_gen_axis_counter #(.W(RW)) u_v_axis (
        .clk       (Clk),
        .rst       (Rst),
        .advance   (h_wrap),
        .len_act   (v_act_sh),
        .len_fp    (RW'(v_fp_sh)),
        .len_sp    (RW'(v_sp_sh)),
        .len_bp    (RW'(v_bp_sh)),
        .phase_nxt (v_phase_nxt),
        .coord_nxt (v_coord_nxt),
        .wrap      (v_wrap)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            h_fp_sh     <= '0;
            h_bp_sh     <= '0;
            h_sp_sh     <= '0;
            h_act_sh    <= '0;
            v_fp_sh     <= '0;
            v_bp_sh     <= '0;
            v_sp_sh     <= '0;
            v_act_sh    <= '0;
            primed      <= 1'b0;
            pending     <= 1'b0;
            Hsync       <= 1'b1;
            Vsync       <= 1'b1;
            Display_en  <= 1'b0;
            Pixel_x     <= '0;
            Pixel_y     <= '0;
            Frame_start <= 1'b0;
        end else begin
            if (reload) begin
                h_fp_sh  <= H_front_porch;
                h_bp_sh  <= H_back_porch;
                h_sp_sh  <= H_sync_pulse;
                h_act_sh <= H_count_max;
                v_fp_sh  <= V_front_porch;
                v_bp_sh  <= V_back_porch;
                v_sp_sh  <= V_sync_pulse;
                v_act_sh <= V_count_max;
            end
            primed <= 1'b1;
            if (!primed || frame_last) begin
                pending <= 1'b0;
            end else if (Load_config) begin
                pending <= 1'b1;
            end

            Hsync       <= (h_phase_nxt != PH_SYNC);
            Vsync       <= (v_phase_nxt != PH_SYNC);
            Display_en  <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            Pixel_x     <= h_coord_nxt;
            Pixel_y     <= v_coord_nxt;
            Frame_start <= !primed || frame_last;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Advances together with each new frame, so it reads k throughout frame k.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Frame_count <= 8'd0;
        end else if (frame_last) begin
            Frame_count <= Frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Load_config = 1'b0;
    logic [7:0]  H_front_porch, H_back_porch, H_sync_pulse;
    logic [7:0]  V_front_porch, V_back_porch, V_sync_pulse;
    logic [10:0] H_count_max, V_count_max;
    logic        Hsync, Vsync, Display_en, Frame_start;
    logic [10:0] Pixel_x, Pixel_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0]  Frame_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    vga_timing_gen dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Load_config   (Load_config),
        .H_front_porch (H_front_porch),
        .H_back_porch  (H_back_porch),
        .H_sync_pulse  (H_sync_pulse),
        .H_count_max   (H_count_max),
        .V_front_porch (V_front_porch),
        .V_back_porch  (V_back_porch),
        .V_sync_pulse  (V_sync_pulse),
        .V_count_max   (V_count_max),
        .Hsync         (Hsync),
        .Vsync         (Vsync),
        .Display_en    (Display_en),
        .Pixel_x       (Pixel_x),
        .Pixel_y       (Pixel_y),
        .Frame_start   (Frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .Frame_count   (Frame_count)
`endif
    );

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb);
        H_count_max   = 11'(ha);
        H_front_porch = 8'(hf);
        H_sync_pulse  = 8'(hs);
        H_back_porch  = 8'(hb);
        V_count_max   = 11'(va);
        V_front_porch = 8'(vf);
        V_sync_pulse  = 8'(vs);
        V_back_porch  = 8'(vb);
    endtask

    // ---------------- behavioural model: outputs from frame position ----------------
    int m_mode = 0;      // 0: reset or INIT cycle, 1: running
    int m_t    = 0;      // cycle index inside the current frame
    int m_fc   = 0;
    bit m_pend = 1'b0;
    int c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;
    int m_ha, m_va, m_l, m_nl, m_f, m_col, m_line, m_hr, m_vr;
    logic [31:0] m_got, m_exp;

    function automatic int region(input int pos, input int act, input int fp, input int sp);
        if (pos < act) return 0;
        if (pos < act + fp) return 1;
        if (pos < act + fp + sp) return 2;
        return 3;
    endfunction

    task automatic model_load();
        c_ha = int'(H_count_max);   c_hf = int'(H_front_porch);
        c_hs = int'(H_sync_pulse);  c_hb = int'(H_back_porch);
        c_va = int'(V_count_max);   c_vf = int'(V_front_porch);
        c_vs = int'(V_sync_pulse);  c_vb = int'(V_back_porch);
    endtask

    always @(negedge Clk) begin
        m_got = {6'd0, Hsync, Vsync, Display_en, Frame_start, Pixel_x, Pixel_y};
        if (Rst || m_mode == 0) begin
            m_exp = {6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0};
            check("model_idle", int'(m_got), int'(m_exp));
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("model_fcnt_idle", int'(Frame_count), 0);
`endif
            if (Rst) begin
                m_mode = 0;
                m_fc   = 0;
            end else begin
                model_load();
                m_t    = 0;
                m_pend = 1'b0;
                m_mode = 1;
            end
        end else begin
            m_ha   = (c_ha == 0) ? 1 : c_ha;
            m_va   = (c_va == 0) ? 1 : c_va;
            m_l    = m_ha + c_hf + c_hs + c_hb;
            m_nl   = m_va + c_vf + c_vs + c_vb;
            m_f    = m_l * m_nl;
            m_col  = m_t % m_l;
            m_line = m_t / m_l;
            m_hr   = region(m_col, m_ha, c_hf, c_hs);
            m_vr   = region(m_line, m_va, c_vf, c_vs);
            m_exp  = {6'd0, 1'(m_hr != 2), 1'(m_vr != 2), 1'(m_hr == 0 && m_vr == 0),
                      1'(m_t == 0), 11'((m_hr == 0) ? m_col : 0), 11'((m_vr == 0) ? m_line : 0)};
            check("model_run", int'(m_got), int'(m_exp));
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("model_fcnt", int'(Frame_count), m_fc);
`endif
            if (Load_config) m_pend = 1'b1;
            if (m_t == m_f - 1) begin
                m_t  = 0;
                m_fc = (m_fc + 1) % 256;
                if (m_pend) begin
                    model_load();
                    m_pend = 1'b0;
                end
            end else begin
                m_t++;
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_fs(output int n, input int bound);
        step(1);
        n = 1;
        while (!Frame_start && n < bound) begin
            step(1);
            n++;
        end
        if (!Frame_start) begin
            total++;
            $display("FAIL wait_frame_start: no Frame_start within %0d cycles", bound);
        end
    endtask

    int n;

    initial begin
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
        step(3);
        check("reset_outputs", int'({Hsync, Vsync, Display_en, Frame_start, Pixel_x, Pixel_y}),
              int'({1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0}));

        // Test 1: base timing, line 8, frame 48
        Rst = 1'b0;
        check("init_cycle_de", int'(Display_en), 0);
        check("init_cycle_fs", int'(Frame_start), 0);
        step(1);
        check("t1_first_pixel", int'({Frame_start, Display_en, Pixel_x, Pixel_y}),
              int'({1'b1, 1'b1, 11'd0, 11'd0}));
        step(5);  check("t1_hsync_c5", int'(Hsync), 0);
        step(2);  check("t1_c7_hs_de", int'({Hsync, Display_en}), int'(2'b10));
        step(2);  check("t1_c9_xy", int'({Display_en, Pixel_x, Pixel_y}), int'({1'b1, 11'd1, 11'd1}));
        step(23); check("t1_vsync_c32", int'(Vsync), 0);
        step(8);  check("t1_vsync_c40", int'(Vsync), 1);
        wait_fs(n, 60); check("t1_frame_len", n, 8);

        // Test 2: mid-frame load, current frame untouched
        step(10);
        set_cfg(4, 0, 2, 1, 3, 1, 1, 0);
        Load_config = 1'b1; step(1); Load_config = 1'b0;
        wait_fs(n, 60); check("t2_old_frame_rest", n, 37);
        step(7);  check("t2_line7", int'({Display_en, Pixel_x, Pixel_y}), int'({1'b1, 11'd0, 11'd1}));
        wait_fs(n, 60); check("t2_frame35", n, 28);

        // Test 3: load on the final cycle of the frame
        step(34);
        set_cfg(2, 1, 1, 1, 2, 0, 1, 1);
        Load_config = 1'b1; step(1); Load_config = 1'b0;
        check("t3_fs_next", int'(Frame_start), 1);
        step(5);  check("t3_line5", int'({Pixel_x, Pixel_y}), int'({11'd0, 11'd1}));
        wait_fs(n, 60); check("t3_frame20", n, 15);

        // Test 4: two pulses, then a plain input change before the boundary
        step(3);
        set_cfg(6, 2, 2, 2, 5, 1, 1, 1);
        Load_config = 1'b1; step(1); Load_config = 1'b0;
        step(4);
        set_cfg(5, 1, 1, 1, 4, 1, 1, 1);
        Load_config = 1'b1; step(1); Load_config = 1'b0;
        step(3);
        set_cfg(3, 0, 1, 0, 2, 1, 1, 0);
        wait_fs(n, 60); check("t4_old_frame_rest", n, 8);
        step(4);  check("t4_line4", int'({Display_en, Pixel_x, Pixel_y}), int'({1'b1, 11'd0, 11'd1}));
        wait_fs(n, 60); check("t4_frame16", n, 12);

        // Test 5: asynchronous reset at x=2, y=1
        step(6);  check("t5_pre_reset_xy", int'({Pixel_x, Pixel_y}), int'({11'd2, 11'd1}));
        Rst = 1'b1;
        #1;
        check("t5_async_reset", int'({Hsync, Vsync, Display_en, Frame_start, Pixel_x, Pixel_y}),
              int'({1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0}));
        step(2);
        Rst = 1'b0;
        check("t5_init_de", int'(Display_en), 0);
        step(1);
        check("t5_restart", int'({Frame_start, Pixel_x, Pixel_y}), int'({1'b1, 11'd0, 11'd0}));

        // Test 6: many short frames, counter wrap
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("t6_fcnt_0", int'(Frame_count), 0);
`endif
        set_cfg(1, 0, 1, 0, 1, 0, 1, 0);
        Load_config = 1'b1; step(1); Load_config = 1'b0;
        for (int k = 1; k <= 257; k++) begin
            wait_fs(n, 40);
            check("t6_frame_len", n, (k == 1) ? 15 : 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("t6_fcnt", int'(Frame_count), k % 256);
`endif
        end
        step(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
